ult_min_scheduler: RTL and testbench

- Arbitrates among N requesters, each presenting an unsigned key, and grants the requester with the smallest key.
- Time-shares one unsigned less-than comparator across requesters instead of building an N-way compare tree.
- Sits in front of a shared resource as its scheduler. The downstream consumer accepts grants over a valid/ready handshake.

---
 rtl/ult_min_scheduler_pkg.sv | 18 +
 rtl/ult_min_scheduler_cmp.sv | 13 +
 rtl/ult_min_scheduler.sv | 147 ++++++++++++++
 tb/tb_ult_min_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ult_min_scheduler_pkg.sv
// Shared definitions for the min-key scheduler: FSM encoding and a
// constant-evaluable clog2 used to size the grant index.
package ult_min_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ult_min_scheduler_cmp.sv
// Unsigned less-than comparator; the single compare resource that the
// scheduler time-shares across all requesters.
module ult_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out
);

  assign out = (in0 < in1);

endmodule

// File: rtl/ult_min_scheduler.sv
// Smallest-key scheduler: snapshots the requests, walks them one per cycle
// through a shared comparator and presents the winner on a valid/ready grant.
module ult_min_scheduler
  import ult_min_scheduler_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int IDX_W = clog2(N)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] keys,
  input  logic               grant_ready,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [WIDTH-1:0]   grant_key,
  output logic               busy
);

  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [N-1:0]       mask_r;
  logic [N-1:0]       mask_nxt_s;
  logic [N*WIDTH-1:0] keys_r;
  logic [N*WIDTH-1:0] keys_nxt_s;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   ptr_nxt_s;
  logic [IDX_W-1:0]   best_idx_r;
  logic [IDX_W-1:0]   best_idx_nxt_s;
  logic [WIDTH-1:0]   best_key_r;
  logic [WIDTH-1:0]   best_key_nxt_s;
  logic               best_valid_r;
  logic               best_valid_nxt_s;
  logic               grant_valid_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic [WIDTH-1:0]   grant_key_r;
  logic               busy_r;
  logic [WIDTH-1:0]   cur_key_s;
  logic               lt_s;
  logic               take_s;

  assign cur_key_s = keys_r[ptr_r*WIDTH +: WIDTH];

  ult_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .in0 (cur_key_s),
    .in1 (best_key_r),
    .out (lt_s)
  );

  // Strict less-than keeps the earlier (lower-index) winner on ties.
  assign take_s = mask_r[ptr_r] && (!best_valid_r || lt_s);

  // Next-state, snapshot and best-so-far update logic.
  always_comb begin
    state_nxt_s      = state_r;
    mask_nxt_s       = mask_r;
    keys_nxt_s       = keys_r;
    ptr_nxt_s        = ptr_r;
    best_idx_nxt_s   = best_idx_r;
    best_key_nxt_s   = best_key_r;
    best_valid_nxt_s = best_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (req != {N{1'b0}}) begin
          state_nxt_s      = ST_SCAN;
          mask_nxt_s       = req;
          keys_nxt_s       = keys;
          ptr_nxt_s        = {IDX_W{1'b0}};
          best_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (take_s) begin
          best_idx_nxt_s   = ptr_r;
          best_key_nxt_s   = cur_key_s;
          best_valid_nxt_s = 1'b1;
        end else begin
          best_valid_nxt_s = best_valid_r;
        end
        if (ptr_r == PTR_LAST) begin
          state_nxt_s = ST_GRANT;
        end else begin
          ptr_nxt_s = ptr_r + PTR_ONE;
        end
      end
      ST_GRANT: begin
        if (grant_valid_r && grant_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, snapshot and registered grant outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r       <= ST_IDLE;
      mask_r        <= {N{1'b0}};
      keys_r        <= {(N*WIDTH){1'b0}};
      ptr_r         <= {IDX_W{1'b0}};
      best_idx_r    <= {IDX_W{1'b0}};
      best_key_r    <= {WIDTH{1'b0}};
      best_valid_r  <= 1'b0;
      grant_valid_r <= 1'b0;
      grant_idx_r   <= {IDX_W{1'b0}};
      grant_key_r   <= {WIDTH{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      mask_r        <= mask_nxt_s;
      keys_r        <= keys_nxt_s;
      ptr_r         <= ptr_nxt_s;
      best_idx_r    <= best_idx_nxt_s;
      best_key_r    <= best_key_nxt_s;
      best_valid_r  <= best_valid_nxt_s;
      grant_valid_r <= (state_nxt_s == ST_GRANT);
      busy_r        <= (state_nxt_s != ST_IDLE);
      // Grant payload is captured once, on the final scan step, then held.
      if ((state_r == ST_SCAN) && (state_nxt_s == ST_GRANT)) begin
        grant_idx_r <= best_idx_nxt_s;
        grant_key_r <= best_key_nxt_s;
      end else begin
        grant_idx_r <= grant_idx_r;
        grant_key_r <= grant_key_r;
      end
    end
  end

  assign grant_valid = grant_valid_r;
  assign grant_idx   = grant_idx_r;
  assign grant_key   = grant_key_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ult_min_scheduler.sv
// Directed bench for ult_min_scheduler (N=4, WIDTH=8): a vector table for
// single grants plus hand sequences for backpressure, reset and back-to-back.
module tb_ult_min_scheduler;

  logic        CLK;
  logic        RESET;
  logic [3:0]  req;
  logic [31:0] keys;
  logic        grant_ready;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [7:0]  grant_key;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] keys;
    logic [1:0]  idx;
    logic [7:0]  key;
  } vec_t;

  vec_t vecs[8];

  ult_min_scheduler #(
    .N     (4),
    .WIDTH (8)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req         (req),
    .keys        (keys),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_key   (grant_key),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    checks   = 0;
    failures = 0;

    // keys packed as {key3, key2, key1, key0}
    vecs[0] = '{4'b1111, {8'h05, 8'h20, 8'h10, 8'h30}, 2'd3, 8'h05};
    vecs[1] = '{4'b0110, {8'h00, 8'h10, 8'h10, 8'h01}, 2'd1, 8'h10};
    vecs[2] = '{4'b0011, {8'h00, 8'h00, 8'h7F, 8'h80}, 2'd1, 8'h7F};
    vecs[3] = '{4'b1111, {8'h55, 8'h55, 8'h55, 8'h55}, 2'd0, 8'h55};
    vecs[4] = '{4'b1000, {8'h00, 8'h01, 8'h02, 8'h03}, 2'd3, 8'h00};
    vecs[5] = '{4'b0101, {8'h00, 8'h00, 8'h11, 8'hFF}, 2'd2, 8'h00};
    vecs[6] = '{4'b1001, {8'h00, 8'hAA, 8'hAA, 8'h00}, 2'd0, 8'h00};
    vecs[7] = '{4'b1110, {8'hFE, 8'hFF, 8'hFF, 8'h00}, 2'd3, 8'hFE};

    RESET       = 1'b1;
    req         = 4'b0000;
    keys        = 32'h0000_0000;
    grant_ready = 1'b0;
    tick();
    tick();
    chk("reset_valid", {31'd0, grant_valid}, 32'd0);
    chk("reset_idx",   {30'd0, grant_idx},   32'd0);
    chk("reset_key",   {24'd0, grant_key},   32'd0);
    chk("reset_busy",  {31'd0, busy},        32'd0);
    RESET = 1'b0;
    tick();

    // Single grants: snapshot at edge 0, grant visible after edge N, gone after N+1.
    for (int i = 0; i < 8; i++) begin
      req         = vecs[i].req;
      keys        = vecs[i].keys;
      grant_ready = 1'b1;
      tick();
      req  = 4'b0000;
      keys = ~vecs[i].keys;
      chk($sformatf("v%0d_busy_scan", i), {31'd0, busy}, 32'd1);
      tick();
      tick();
      tick();
      chk($sformatf("v%0d_valid_early", i), {31'd0, grant_valid}, 32'd0);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, grant_valid}, 32'd1);
      chk($sformatf("v%0d_idx", i),   {30'd0, grant_idx},   {30'd0, vecs[i].idx});
      chk($sformatf("v%0d_key", i),   {24'd0, grant_key},   {24'd0, vecs[i].key});
      tick();
      chk($sformatf("v%0d_valid_drop", i), {31'd0, grant_valid}, 32'd0);
      chk($sformatf("v%0d_busy_idle", i),  {31'd0, busy},        32'd0);
    end

    // Backpressure with keys changed after the snapshot.
    req         = 4'b0001;
    keys        = {8'h00, 8'h00, 8'h00, 8'hFF};
    grant_ready = 1'b0;
    tick();
    req  = 4'b0000;
    keys = 32'h0000_0000;
    for (int k = 1; k <= 4; k++) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_valid_%0d", k), {31'd0, grant_valid}, 32'd1);
      chk($sformatf("bp_idx_%0d", k),   {30'd0, grant_idx},   32'd0);
      chk($sformatf("bp_key_%0d", k),   {24'd0, grant_key},   32'h0000_00FF);
      tick();
    end
    chk("bp_still_valid", {31'd0, grant_valid}, 32'd1);
    grant_ready = 1'b1;
    tick();
    chk("bp_accepted", {31'd0, grant_valid}, 32'd0);
    chk("bp_idle",     {31'd0, busy},        32'd0);

    // Reset mid-scan aborts without a grant.
    req  = 4'b1111;
    keys = {8'h01, 8'h02, 8'h03, 8'h04};
    tick();
    req = 4'b0000;
    tick();
    RESET = 1'b1;
    tick();
    chk("rst_busy",  {31'd0, busy},        32'd0);
    chk("rst_valid", {31'd0, grant_valid}, 32'd0);
    RESET = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (grant_valid === 1'b1) seen = 1'b1;
    end
    chk("rst_no_grant", {31'd0, seen}, 32'd0);

    // Back-to-back grants with req held: visible after edges 4 and 10.
    req         = 4'b1000;
    keys        = {8'h42, 8'h00, 8'h00, 8'h00};
    grant_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("b2b_valid_e%0d", k), {31'd0, grant_valid},
          ((k == 4) || (k == 10)) ? 32'd1 : 32'd0);
      if ((k == 4) || (k == 10)) begin
        chk($sformatf("b2b_idx_e%0d", k), {30'd0, grant_idx}, 32'd3);
        chk($sformatf("b2b_key_e%0d", k), {24'd0, grant_key}, 32'h0000_0042);
      end
    end
    req   = 4'b0000;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
